ipml_sync_prefetch_fifo_v2_0: RTL

Single-clock, first-word-fall-through FIFO: an inferred synchronous-read RAM with a 2-entry prefetch output buffer.
- Sustains one write and one read per cycle.
- Adds a synchronous flush, an occupancy level, parameterised almost-full/almost-empty thresholds and sticky overflow/underflow flags.
- Sits in the FFT datapath wherever producer and consumer share a clock, replacing dual-clock prefetch FIFOs configured as "SYN".

---
 rtl/ipml_fifo_pkg.sv | 30 +++
 rtl/ipml_skid_buf_v2_0.sv | 72 +++++++
 rtl/ipml_sync_prefetch_fifo_v2_0.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ipml_fifo_pkg.sv
// Purpose  : shared constants, types and helpers for the ipml FIFO family.
// Latency  : n/a (package only).
// Backpress: n/a (package only).
//
// Contents : CAPACITY() gives total words held by a prefetch FIFO of a given
//            RAM address width, LEVEL_PAD_W is the extra level-counter width
//            on top of DEPTH_W, and DEF_* are the default threshold settings.
package ipml_fifo_pkg;

    // Level counters are DEPTH_W + LEVEL_PAD_W bits wide, enough for the RAM
    // plus the two prefetch slots.
    localparam int LEVEL_PAD_W   = 2;

    // Default thresholds: almost_empty at <= 4 words, almost_full at
    // 4 words short of the RAM size.
    localparam int DEF_AE_LEVEL  = 4;
    localparam int DEF_AF_MARGIN = 4;

    // Sticky error flags, cleared only by reset or flush.
    typedef struct packed {
        logic overflow;
        logic underflow;
    } fifo_err_t;

    // Words held by a prefetch FIFO: the full RAM plus the 2-entry buffer.
    function automatic int CAPACITY(input int depth_w);
        return (1 << depth_w) + 2;
    endfunction

endpackage

// File: rtl/ipml_skid_buf_v2_0.sv
// Purpose  : 2-entry output buffer that presents the FIFO head word.
// Latency  : 1 cycle from in_valid to out_valid.
// Backpress: none on the input side; the upstream slot count guarantees space.
//
// Ports    : clk/rst (async active-high), flush (sync clear),
//            in_valid/in_data (returned RAM word),
//            out_ready/out_valid/out_data (head word, pop = out_ready & out_valid).
module ipml_skid_buf_v2_0 #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    logic [1:0]        cnt;
    logic [DATA_W-1:0] buf0;   // head, drives out_data directly
    logic [DATA_W-1:0] buf1;   // second-oldest word
    logic              pop;

    assign pop       = out_ready & (cnt != 2'd0);
    assign out_valid = (cnt != 2'd0);
    assign out_data  = buf0;

    // buf0 is only rewritten when it is empty or being popped, so the head
    // word holds steady while out_valid & !out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= 2'd0;
            buf0 <= '0;
            buf1 <= '0;
        end else if (flush) begin
            cnt  <= 2'd0;
        end else begin
            unique case (cnt)
                2'd0: begin
                    if (in_valid) begin
                        buf0 <= in_data;
                        cnt  <= 2'd1;
                    end
                end
                2'd1: begin
                    if (pop && in_valid) begin
                        buf0 <= in_data;
                    end else if (pop) begin
                        cnt  <= 2'd0;
                    end else if (in_valid) begin
                        buf1 <= in_data;
                        cnt  <= 2'd2;
                    end
                end
                default: begin
                    // Full: a push can only arrive together with a pop.
                    if (pop) begin
                        buf0 <= buf1;
                        if (in_valid) begin
                            buf1 <= in_data;
                        end else begin
                            cnt  <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/ipml_sync_prefetch_fifo_v2_0.sv
// Purpose  : single-clock first-word-fall-through FIFO, sync-read RAM + 2-entry prefetch.
// Latency  : write into empty FIFO shows rd_vld 2 edges after the accept edge.
// Backpress: wr_vld drops when the RAM is full; rd_vld low when no head word.
//
// Ports    : clk, rst (async active-high), flush (sync clear, highest priority),
//            wr_data/wr_en/wr_vld (write accepted on wr_en & wr_vld),
//            rd_data/rd_en/rd_vld (pop on rd_en & rd_vld), level (total words),
//            almost_full/almost_empty (registered thresholds), overflow/underflow (sticky).
module ipml_sync_prefetch_fifo_v2_0
    import ipml_fifo_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int DEPTH_W  = 10,
    parameter int AF_LEVEL = (1 << DEPTH_W) - DEF_AF_MARGIN,
    parameter int AE_LEVEL = DEF_AE_LEVEL
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          wr_en,
    output logic                          wr_vld,
    output logic [DATA_W-1:0]             rd_data,
    input  logic                          rd_en,
    output logic                          rd_vld,
    output logic [DEPTH_W+LEVEL_PAD_W-1:0] level,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int RAM_WORDS = 1 << DEPTH_W;
    localparam int CNT_W     = DEPTH_W + 1;
    localparam int LVL_W     = DEPTH_W + LEVEL_PAD_W;
    localparam int CAP       = CAPACITY(DEPTH_W);

    localparam logic [CNT_W-1:0] RAM_FULL = CNT_W'(RAM_WORDS);
    // Thresholds beyond the capacity are clamped so they stay representable:
    // an unreachable almost_full never fires, an oversized almost_empty always does.
    localparam logic [LVL_W-1:0] AF_THR = LVL_W'((AF_LEVEL > CAP) ? CAP + 1 : AF_LEVEL);
    localparam logic [LVL_W-1:0] AE_THR = LVL_W'((AE_LEVEL > CAP) ? CAP : AE_LEVEL);

    // RAM and its registered read port
    logic [DATA_W-1:0]  mem [RAM_WORDS];
    logic [DATA_W-1:0]  ret_dat;

    logic [DEPTH_W-1:0] wr_ptr,  wr_ptr_nxt;
    logic [DEPTH_W-1:0] rd_ptr,  rd_ptr_nxt;
    logic [CNT_W-1:0]   ram_cnt, ram_cnt_nxt;
    // Words issued from the RAM and not yet popped (return stage + buffer).
    logic [1:0]         slots,   slots_nxt;
    logic               ret_vld, ret_vld_nxt;
    logic [LVL_W-1:0]   level_nxt;
    fifo_err_t          err_q,   err_nxt;

    logic accept;
    logic pop;
    logic issue;

    assign accept = wr_en & wr_vld & ~flush;
    assign pop    = rd_en & rd_vld & ~flush;
    // ram_cnt is the registered count, so a word written this cycle cannot
    // be read back in the same cycle; this also keeps RAM read and write
    // addresses apart.
    assign issue  = (ram_cnt != '0) & ((slots < 2'd2) | pop) & ~flush;

    always_comb begin
        wr_ptr_nxt  = wr_ptr + DEPTH_W'(accept);
        rd_ptr_nxt  = rd_ptr + DEPTH_W'(issue);
        ram_cnt_nxt = ram_cnt + CNT_W'(accept) - CNT_W'(issue);
        slots_nxt   = slots + 2'(issue) - 2'(pop);
        level_nxt   = level + LVL_W'(accept) - LVL_W'(pop);
        ret_vld_nxt = issue;
        err_nxt.overflow  = err_q.overflow  | (wr_en & ~wr_vld);
        err_nxt.underflow = err_q.underflow | (rd_en & ~rd_vld);
        if (flush) begin
            wr_ptr_nxt  = '0;
            rd_ptr_nxt  = '0;
            ram_cnt_nxt = '0;
            slots_nxt   = 2'd0;
            level_nxt   = '0;
            err_nxt     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            ram_cnt      <= '0;
            slots        <= 2'd0;
            ret_vld      <= 1'b0;
            level        <= '0;
            wr_vld       <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            err_q        <= '0;
        end else begin
            wr_ptr       <= wr_ptr_nxt;
            rd_ptr       <= rd_ptr_nxt;
            ram_cnt      <= ram_cnt_nxt;
            slots        <= slots_nxt;
            ret_vld      <= ret_vld_nxt;
            level        <= level_nxt;
            wr_vld       <= (ram_cnt_nxt != RAM_FULL);
            almost_full  <= (level_nxt >= AF_THR);
            almost_empty <= (level_nxt <= AE_THR);
            err_q        <= err_nxt;
        end
    end

    // Inferred RAM: synchronous write, registered read. Contents are not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= wr_data;
        end
        if (issue) begin
            ret_dat <= mem[rd_ptr];
        end
    end

    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

    // A word returning at a flush edge is dropped by the buffer's own flush.
    ipml_skid_buf_v2_0 #(
        .DATA_W (DATA_W)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (ret_vld),
        .in_data   (ret_dat),
        .out_ready (rd_en & ~flush),
        .out_valid (rd_vld),
        .out_data  (rd_data)
    );

endmodule
